// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write counters, RAW/capacity stall logic.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback resolve a last pending source.
module id_scoreboard #(
    parameter int unsigned REG_FILE_DEPTH  = 32,
    parameter int unsigned MAX_PENDING     = 3,
    parameter int unsigned STALL_CNT_WIDTH = 16,
    localparam int unsigned REG_FILE_ADDR  = $clog2(REG_FILE_DEPTH)
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_id_valid,
    input  logic [REG_FILE_ADDR-1:0]   i_id_rs1,
    input  logic [REG_FILE_ADDR-1:0]   i_id_rs2,
    input  logic                       i_id_rs1_used,
    input  logic                       i_id_rs2_used,
    input  logic [REG_FILE_ADDR-1:0]   i_id_rd,
    input  logic                       i_id_rd_we,
    input  logic                       i_flush,
    input  logic                       i_wb_en,
    input  logic [REG_FILE_ADDR-1:0]   i_wb_addr,
    input  logic                       i_clr_stats,
    output logic                       o_stall,
    output logic                       o_issue,
    output logic                       o_busy_any,
    output logic [STALL_CNT_WIDTH-1:0] o_stall_cycles,
    output logic                       o_err
);

    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [REG_FILE_DEPTH];
    logic [CNT_W-1:0] cnt_d [REG_FILE_DEPTH];

    logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
    logic             rs1_resolved, rs2_resolved;
    logic             rs1_haz, rs2_haz, cap_haz;
    logic             rd_tracked, issue_track;
    logic             wb_live, wb_retire, wb_err;
    logic [REG_FILE_DEPTH-1:0] inc_vec, dec_vec;

    assign rs1_cnt = cnt_q[i_id_rs1];
    assign rs2_cnt = cnt_q[i_id_rs2];
    assign rd_cnt  = cnt_q[i_id_rd];
    assign wb_cnt  = cnt_q[i_wb_addr];

`ifdef SCOREBOARD_WB_BYPASS_EN
    // Register file writes through, so the final outstanding write is readable this cycle.
    assign rs1_resolved = i_wb_en && (i_wb_addr == i_id_rs1) && (rs1_cnt == CNT_ONE);
    assign rs2_resolved = i_wb_en && (i_wb_addr == i_id_rs2) && (rs2_cnt == CNT_ONE);
`else
    assign rs1_resolved = 1'b0;
    assign rs2_resolved = 1'b0;
`endif

    assign rs1_haz    = i_id_rs1_used && (rs1_cnt != '0) && !rs1_resolved;
    assign rs2_haz    = i_id_rs2_used && (rs2_cnt != '0) && !rs2_resolved;
    assign rd_tracked = i_id_rd_we && (i_id_rd != '0);
    assign cap_haz    = rd_tracked && (rd_cnt == CNT_MAX) && !(i_wb_en && (i_wb_addr == i_id_rd));

    assign o_stall = i_reset_n && i_id_valid && !i_flush && (rs1_haz || rs2_haz || cap_haz);
    assign o_issue = i_reset_n && i_id_valid && !i_flush && !o_stall;

    assign issue_track = o_issue && rd_tracked;
    assign wb_live     = i_wb_en && (i_wb_addr != '0);
    assign wb_retire   = wb_live && (wb_cnt != '0);
    assign wb_err      = wb_live && (wb_cnt == '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < REG_FILE_DEPTH; r++) begin
            inc_vec[r] = issue_track && (i_id_rd == REG_FILE_ADDR'(r));
            dec_vec[r] = wb_retire && (i_wb_addr == REG_FILE_ADDR'(r));
        end
    end

    // Simultaneous issue and retire to one register cancel out.
    always_comb begin
        for (int r = 0; r < REG_FILE_DEPTH; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_comb begin
        o_busy_any = 1'b0;
        for (int r = 0; r < REG_FILE_DEPTH; r++) begin
            o_busy_any = o_busy_any || (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int r = 0; r < REG_FILE_DEPTH; r++) begin
                cnt_q[r] <= '0;
            end
            o_stall_cycles <= '0;
            o_err          <= 1'b0;
        end else begin
            for (int r = 0; r < REG_FILE_DEPTH; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            if (i_clr_stats) begin
                o_stall_cycles <= '0;
                o_err          <= 1'b0;
            end else begin
                if (o_stall && (o_stall_cycles != '1)) begin
                    o_stall_cycles <= o_stall_cycles + 1'b1;
                end
                if (wb_err) begin
                    o_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: behavioural pending-count model, directed scenarios
// plus randomized traffic; works with or without SCOREBOARD_WB_BYPASS_EN.
module tb_id_scoreboard;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int MAXP  = 3;
    localparam int SW    = 10;
    localparam int SMAX  = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid, rs1_used, rs2_used, rd_we, flush, wb_en, clr;
    logic [AW-1:0] rs1, rs2, rd, wb_addr;
    logic          o_stall, o_issue, o_busy_any, o_err;
    logic [SW-1:0] o_stall_cycles;

    always #5 clk = ~clk;

    id_scoreboard #(
        .REG_FILE_DEPTH (DEPTH),
        .MAX_PENDING    (MAXP),
        .STALL_CNT_WIDTH(SW)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_id_valid    (valid),
        .i_id_rs1      (rs1),
        .i_id_rs2      (rs2),
        .i_id_rs1_used (rs1_used),
        .i_id_rs2_used (rs2_used),
        .i_id_rd       (rd),
        .i_id_rd_we    (rd_we),
        .i_flush       (flush),
        .i_wb_en       (wb_en),
        .i_wb_addr     (wb_addr),
        .i_clr_stats   (clr),
        .o_stall       (o_stall),
        .o_issue       (o_issue),
        .o_busy_any    (o_busy_any),
        .o_stall_cycles(o_stall_cycles),
        .o_err         (o_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_m [DEPTH];
    bit err_m;
    int stall_m;
    bit exp_stall, exp_issue, exp_busy;
    bit bypass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit src_blocked(input logic [AW-1:0] rs);
        int c = cnt_m[rs];
        if (c == 0) return 1'b0;
        if (bypass && wb_en && wb_addr == rs && c == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_eval();
        bit haz = 1'b0;
        if (rs1_used && src_blocked(rs1)) haz = 1'b1;
        if (rs2_used && src_blocked(rs2)) haz = 1'b1;
        if (rd_we && rd != 0 && cnt_m[rd] == MAXP && !(wb_en && wb_addr == rd)) haz = 1'b1;
        exp_stall = rst_n && valid && !flush && haz;
        exp_issue = rst_n && valid && !flush && !exp_stall;
        exp_busy  = 1'b0;
        for (int i = 0; i < DEPTH; i++) if (cnt_m[i] != 0) exp_busy = 1'b1;
    endfunction

    function automatic void model_update();
        int pre;
        bit err_set = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt_m[i] = 0;
            err_m   = 1'b0;
            stall_m = 0;
            return;
        end
        pre = cnt_m[wb_addr];
        if (exp_issue && rd_we && rd != 0) cnt_m[rd]++;
        if (wb_en && wb_addr != 0) begin
            if (pre > 0) cnt_m[wb_addr]--;
            else err_set = 1'b1;
        end
        if (clr) begin
            stall_m = 0;
            err_m   = 1'b0;
        end else begin
            if (exp_stall && stall_m < SMAX) stall_m++;
            if (err_set) err_m = 1'b1;
        end
    endfunction

    // One clock: compare all outputs against the model mid-cycle, then advance the model.
    task automatic step();
        @(negedge clk);
        model_eval();
        check("o_stall", o_stall, exp_stall);
        check("o_issue", o_issue, exp_issue);
        check("o_busy_any", o_busy_any, exp_busy);
        check("o_stall_cycles", o_stall_cycles, stall_m);
        check("o_err", o_err, err_m);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int d, input bit we, input bit fl, input bit wbe, input int wba,
                       input bit cl);
        valid = v; rs1 = AW'(r1); rs1_used = u1; rs2 = AW'(r2); rs2_used = u2;
        rd = AW'(d); rd_we = we; flush = fl; wb_en = wbe; wb_addr = AW'(wba); clr = cl;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
`ifdef SCOREBOARD_WB_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) cnt_m[i] = 0;
        err_m = 1'b0;
        stall_m = 0;
        rst_n = 1'b0;
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        #1;
        check("lit_reset_issue", o_issue, 0);
        check("lit_reset_stall", o_stall, 0);
        step();
        step();
        check("lit_reset_cycles", o_stall_cycles, 0);
        check("lit_reset_err", o_err, 0);
        rst_n = 1'b1;

        // RAW hazard on x5, resolved by writeback
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step();
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("lit_raw_stall", o_stall, 1);
        repeat (3) step();
        check("lit_raw_cycles3", o_stall_cycles, 3);
        drv(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0);
        #1;
        check("lit_wb_same_cycle_stall", o_stall, bypass ? 0 : 1);
        step();
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("lit_after_wb_issue", o_issue, 1);
        step();
        check("lit_raw_cycles_final", o_stall_cycles, bypass ? 3 : 4);

        // Capacity on x7
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        repeat (3) step();
        #1;
        check("lit_cap_stall", o_stall, 1);
        repeat (2) step();
        drv(1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 0);
        #1;
        check("lit_cap_wb_issue", o_issue, 1);
        step();
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        #1;
        check("lit_cap_still_full", o_stall, 1);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        repeat (3) step();
        check("lit_cap_drained", o_busy_any, 0);

        // x0 never tracked; error on stray writeback
        drv(1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        #1;
        check("lit_x0_stall", o_stall, 0);
        check("lit_x0_busy", o_busy_any, 0);
        step();
        check("lit_x0_err", o_err, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step();
        check("lit_err_set", o_err, 1);
        idle();
        repeat (2) step();
        check("lit_err_sticky", o_err, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        check("lit_clr_err", o_err, 0);
        check("lit_clr_cycles", o_stall_cycles, 0);

        // Flush of a hazardous instruction
        drv(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        step();
        drv(1, 4, 1, 0, 0, 4, 1, 1, 0, 0, 0);
        #1;
        check("lit_flush_stall", o_stall, 0);
        check("lit_flush_issue", o_issue, 0);
        step();
        drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("lit_flush_nochange", o_stall, 1);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        step();

        // Saturation, then reset mid-operation
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        repeat (2) step();
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (SMAX + 6) step();
        check("lit_sat", o_stall_cycles, SMAX);
        rst_n = 1'b0;
        #1;
        check("lit_rst_issue", o_issue, 0);
        check("lit_rst_stall", o_stall, 0);
        step();
        check("lit_rst_busy", o_busy_any, 0);
        check("lit_rst_cycles", o_stall_cycles, 0);
        rst_n = 1'b1;
        idle();
        step();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int pick;
            int start;
            rst_n    = ($urandom_range(299) != 0);
            valid    = ($urandom_range(3) != 0);
            rs1      = AW'($urandom_range(7));
            rs2      = AW'($urandom_range(7));
            rs1_used = $urandom_range(1);
            rs2_used = $urandom_range(1);
            rd       = AW'($urandom_range(7));
            rd_we    = ($urandom_range(3) != 0);
            flush    = ($urandom_range(15) == 0);
            clr      = ($urandom_range(63) == 0);
            wb_en    = ($urandom_range(2) == 0);
            pick     = 0;
            start    = $urandom_range(DEPTH - 1);
            for (int i = 0; i < DEPTH; i++) begin
                if (pick == 0 && cnt_m[(start + i) % DEPTH] > 0) pick = (start + i) % DEPTH;
            end
            if ($urandom_range(15) == 0) begin
                pick = $urandom_range(DEPTH - 1);
                if (rd_we && pick == rd) pick = 0;
            end
            wb_addr = AW'(pick);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
